pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter of the pipelined core and selects the next fetch address each cycle.
//  Candidate sources: PC+4, branch target (sign-extended imm<<2), jump target (26-bit index<<2)
//  and jr register target. Applies load-use stalls, flushes IF/ID on redirect, freezes on halt.
//  Sits between the ID-stage control/hazard unit and instruction memory.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  WIDTH     32             address width; only 32 is supported
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  stall         in   1   load-use hazard from ID; hold PC and IF/ID
//  halt          in   1   halt instruction decoded in ID
//  br_taken      in   1   ID branch resolved taken
//  br_imm        in   16  branch immediate (word offset, signed)
//  jump          in   1   j/jal in ID
//  j_index       in   26  jump instruction index
//  jr            in   1   jr in ID
//  jr_addr       in   32  forwarded rs value for jr
//  id_pc_plus4   in   32  PC+4 of the instruction currently in ID
//  pc            out  32  current fetch address
//  pc_plus4      out  32  pc + 4 (mod 2^32), to IF/ID
//  fetch_valid   out  1   pc is a valid fetch this cycle
//  if_id_write   out  1   IF/ID register enable
//  if_id_flush   out  1   zero IF/ID on next edge
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=BOOT, fetch_valid=0, if_id_write=0, if_id_flush=0.
//  FSM states BOOT, RUN, HALT:
//   BOOT: one cycle, pc unchanged, fetch_valid=0, if_id_flush=1 -> RUN.
//   RUN : fetch_valid=1. Per-cycle priority: stall > halt > jr > jump > br_taken > sequential.
//         stall=1: pc held, if_id_write=0, if_id_flush=0; redirect/halt inputs ignored
//           (ID re-presents them next cycle).
//         halt=1: pc held, if_id_write=0, if_id_flush=1 -> HALT.
//         redirect (jr|jump|br_taken): pc <= target, if_id_write=1, if_id_flush=1.
//         none: pc <= pc+4, if_id_write=1, if_id_flush=0.
//   HALT: pc frozen, fetch_valid=0, if_id_write=0, if_id_flush=0; all inputs ignored; exit only via reset.
//  Targets (all mod 2^32, no overflow detection):
//   branch = id_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00}
//   jump   = {id_pc_plus4[31:28], j_index, 2'b00}
//   jr     = {jr_addr[31:2], 2'b00} (low bits forced to 0; pc is always word-aligned)
//  pc_plus4 is combinational from pc. if_id_flush and if_id_write are combinational from state + inputs.
//  Wrap-around: pc=32'hFFFF_FFFC sequential -> 32'h0000_0000.
//  Reset mid-redirect: reset wins immediately; no partial update.
// CONFIGURATION
//  PC_SEQ_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//   stall_cnt increments on each RUN cycle with stall=1.
//   flush_cnt increments on each RUN cycle with an accepted redirect.
//   Both saturate at 32'hFFFF_FFFF and reset to 0.
//  PC_SEQ_PERF_CNT_EN undefined: counters and their ports do not exist; all other behaviour identical.
// STRUCTURE
//  Shared package/header: state encodings (PCS_BOOT=2'd0, PCS_RUN=2'd1, PCS_HALT=2'd2)
//   and the PC step constant (32'd4).
//  Sub-module pc_target_calc: purely combinational; sign-extend/shift/add for branch,
//   concat for jump, mask for jr. The priority mux and FSM stay in pc_sequencer.
// TESTING
//  T1 reset, RESET_PC=0 -> BOOT one cycle (fetch_valid=0, flush=1), then pc 0,4,8,C on successive edges.
//  T2 pc=0x40, id_pc_plus4=0x3C, br_taken, br_imm=16'hFFFE -> next pc=0x34, flush=1 in that cycle.
//  T3 jump, id_pc_plus4=0x1000_0010, j_index=26'h000_0100 -> pc=0x1000_0400.
//     jr with jr_addr=0x0000_0123 -> pc=0x0000_0120.
//  T4 stall=1 together with br_taken for 2 cycles -> pc held, if_id_write=0, flush=0.
//     Stall drops with br_taken still high -> redirect taken.
//  T5 pc=0xFFFF_FFFC sequential -> pc=0x0; halt -> pc frozen for 10 cycles despite jump=1;
//     reset pulsed mid-cycle -> pc=RESET_PC immediately.
//  T6 (PC_SEQ_PERF_CNT_EN) 3 stall cycles + 2 redirects -> stall_cnt=3, flush_cnt=2;
//     saturation forced at 0xFFFF_FFFF holds.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: state encodings and PC step shared by the PC sequencer files.
package pc_sequencer_pkg;
  typedef enum logic [1:0] {
    PCS_BOOT = 2'd0,
    PCS_RUN  = 2'd1,
    PCS_HALT = 2'd2
  } pcs_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational branch, jump and jr target computation.
module pc_target_calc (
  input  logic [15:0] br_imm,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_addr,
  input  logic [31:0] id_pc_plus4,
  output logic [31:0] br_target,
  output logic [31:0] j_target,
  output logic [31:0] jr_target
);
  assign br_target = id_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_target  = {id_pc_plus4[31:28], j_index, 2'b00};
  assign jr_target = {jr_addr[31:2], 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter FSM with stall/halt/redirect priority; PC_SEQ_PERF_CNT_EN adds stall/flush counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        jump,
  input  logic [25:0] j_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] id_pc_plus4,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        if_id_write,
`ifdef PC_SEQ_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        if_id_flush
);
  pcs_state_t state;
  logic [31:0] br_target, j_target, jr_target, next_pc;
  logic run, redirect, advance;
  pc_target_calc calc (
    .br_imm(br_imm),
    .j_index(j_index),
    .jr_addr(jr_addr),
    .id_pc_plus4(id_pc_plus4),
    .br_target(br_target),
    .j_target(j_target),
    .jr_target(jr_target)
  );
  assign run = state == PCS_RUN;
  assign redirect = jr | jump | br_taken;
  assign advance = run & ~stall;
  assign pc_plus4 = pc + PC_STEP;
  assign if_id_write = advance & ~halt;
  assign if_id_flush = ((state == PCS_BOOT) & ~reset) | (advance & (halt | redirect));
  always_comb next_pc = jr ? jr_target : jump ? j_target : br_taken ? br_target : pc_plus4;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PCS_BOOT;
      pc <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        PCS_BOOT: begin
          state <= PCS_RUN;
          fetch_valid <= 1'b1;
        end
        PCS_RUN: if (!stall) begin
          if (halt) begin
            state <= PCS_HALT;
            fetch_valid <= 1'b0;
          end else pc <= next_pc;
        end
        default: fetch_valid <= 1'b0;
      endcase
    end
  end
`ifdef PC_SEQ_PERF_CNT_EN
  // Both counters saturate rather than wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (run && stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      if (advance && !halt && redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer with directed and random stimulus.
module tb_pc_sequencer;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 0, reset = 1;
  logic stall = 0, halt = 0, br_taken = 0, jump = 0, jr = 0;
  logic [15:0] br_imm = 0;
  logic [25:0] j_index = 0;
  logic [31:0] jr_addr = 0, id_pc_plus4 = 0;
  logic [31:0] pc, pc_plus4;
  logic fetch_valid, if_id_write, if_id_flush;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_scnt, m_fcnt;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic fv, w, f;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit m_booted, m_halted;
  logic [31:0] m_pc;

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .br_taken(br_taken), .br_imm(br_imm), .jump(jump), .j_index(j_index),
    .jr(jr), .jr_addr(jr_addr), .id_pc_plus4(id_pc_plus4),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .if_id_write(if_id_write),
`ifdef PC_SEQ_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .if_id_flush(if_id_flush)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // Monitor: every cycle with a pending expectation is compared mid-cycle
  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    chk("pc", pc, e.pc);
    chk("pc_plus4", pc_plus4, e.pc4);
    chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
    chk("if_id_write", 32'(if_id_write), 32'(e.w));
    chk("if_id_flush", 32'(if_id_flush), 32'(e.f));
  end

  // Called at posedge+1: present inputs for one cycle, predict, then advance to the next posedge+1
  task automatic cycle(input bit s, h, b, input logic [15:0] bi, input bit j,
                       input logic [25:0] ji, input bit r, input logic [31:0] ra, ip);
    exp_t e;
    bit go;
    stall = s; halt = h; br_taken = b; br_imm = bi; jump = j; j_index = ji;
    jr = r; jr_addr = ra; id_pc_plus4 = ip;
    e.pc = m_pc;
    e.pc4 = m_pc + 32'd4;
    e.fv = m_booted && !m_halted;
    go = e.fv && !s;
    e.w = go && !h;
    e.f = !m_booted || (go && (h || r || j || b));
    q.push_back(e);
`ifdef PC_SEQ_PERF_CNT_EN
    if (e.fv && s && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    if (go && !h && (r || j || b) && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
`endif
    if (!m_booted) m_booted = 1;
    else if (go) begin
      if (h) m_halted = 1;
      else if (r) m_pc = ra & ~32'd3;
      else if (j) m_pc = (ip & 32'hF000_0000) | (32'(ji) * 32'd4);
      else if (b) m_pc = ip + 32'(int'($signed(bi)) * 4);
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic seq();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is asserted mid-cycle and takes effect without a clock edge
  task automatic do_reset();
    #3;
    reset = 1;
    q.delete();
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_fv", 32'(fetch_valid), 0);
    chk("rst_write", 32'(if_id_write), 0);
    chk("rst_flush", 32'(if_id_flush), 0);
    @(posedge clk);
    #1;
    reset = 0;
    m_booted = 0; m_halted = 0; m_pc = RPC;
`ifdef PC_SEQ_PERF_CNT_EN
    m_scnt = 0; m_fcnt = 0;
`endif
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    // Boot then sequential 0,4,8,C
    seq();
    chk("t1_boot_done_pc", pc, 32'h0);
    seq(); seq(); seq();
    #1 chk("t1_pc_c", pc, 32'hC);
    // Branch backwards from 0x40
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h40, 0);
    cycle(0, 0, 1, 16'hFFFE, 0, 0, 0, 0, 32'h3C);
    chk("t2_pc", pc, 32'h34);
    // Jump and jr
    cycle(0, 0, 0, 0, 1, 26'h100, 0, 0, 32'h1000_0010);
    chk("t3_jump", pc, 32'h1000_0400);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h123, 0);
    chk("t3_jr", pc, 32'h120);
    // Stall beats a pending branch, then the branch is taken
    cycle(1, 0, 1, 16'h0010, 0, 0, 0, 0, 32'h200);
    cycle(1, 0, 1, 16'h0010, 0, 0, 0, 0, 32'h200);
    chk("t4_held", pc, 32'h120);
    cycle(0, 0, 1, 16'h0010, 0, 0, 0, 0, 32'h200);
    chk("t4_taken", pc, 32'h240);
    // Wrap-around, then halt freezes despite jump
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    seq();
    chk("t5_wrap", pc, 32'h0);
    seq();
    cycle(0, 1, 0, 0, 1, 26'h3FF_FFFF, 0, 0, 32'h5000_0000);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 26'h1234, 0, 0, 32'h5000_0000);
    chk("t5_frozen", pc, 32'h4);
`ifdef PC_SEQ_PERF_CNT_EN
    #1;
    chk("t6_stall_cnt", stall_cnt, 32'd2);
    chk("t6_flush_cnt", flush_cnt, 32'd6);
`endif
    // Reset while a redirect is being presented
    do_reset();
    seq(); seq();
    cycle(0, 0, 0, 0, 1, 26'h2222, 0, 0, 32'h7000_0000);
    do_reset();
    chk("t5_reset_pc", pc, RPC);
`ifdef PC_SEQ_PERF_CNT_EN
    seq();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 16'h4, 0, 0, 0, 0, 32'h100);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h88, 0);
    #1;
    chk("t6_stall3", stall_cnt, 32'd3);
    chk("t6_flush2", flush_cnt, 32'd2);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt;
    m_scnt = 32'hFFFF_FFFF;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_saturate", stall_cnt, 32'hFFFF_FFFF);
    do_reset();
`endif
    // Random blocks, each starting from reset
    for (int blk = 0; blk < 4; blk++) begin
      seq();
      for (int i = 0; i < 80; i++)
        cycle($urandom_range(3) == 0, $urandom_range(99) == 0, $urandom_range(1) == 1,
              16'($urandom), $urandom_range(3) == 0, 26'($urandom), $urandom_range(4) == 0,
              $urandom, $urandom & ~32'd3);
`ifdef PC_SEQ_PERF_CNT_EN
      #1;
      chk("rnd_stall_cnt", stall_cnt, m_scnt);
      chk("rnd_flush_cnt", flush_cnt, m_fcnt);
`endif
      do_reset();
    end
    @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 expected", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
